// File: rtl/riscv_writeback_stage.sv
// Memory-to-writeback pipeline register with result-source selection, load
// formatting, x0 write suppression and a retired-instruction counter.
module riscv_writeback_stage #(
  parameter int XLEN  = 32,
  parameter int N_SRC = 4,
  parameter int CNT_W = 64,
  parameter int SEL_W = $clog2(N_SRC),
  parameter int LSB_W = $clog2(XLEN/8)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_validM,
  input  logic                  i_stallW,
  input  logic                  i_flushW,
  input  logic                  i_ctrl_reg_wr_enM,
  input  logic [SEL_W-1:0]      i_ctrl_result_srcM,
  input  logic [2:0]            i_ctrl_load_typeM,
  input  logic [LSB_W-1:0]      i_mem_addr_lsbM,
  input  logic [N_SRC*XLEN-1:0] i_result_concatM,
  input  logic [4:0]            i_regfile_rd_addrM,
  output logic                  o_validW,
  output logic                  o_ctrl_reg_wr_enW,
  output logic [4:0]            o_regfile_rd_addrW,
  output logic [XLEN-1:0]       o_regfile_rd_dataW,
  output logic [CNT_W-1:0]      o_retire_cnt
);

  logic                  valid_q, valid_d;
  logic                  wr_en_q, wr_en_d;
  logic [SEL_W-1:0]      src_q, src_d;
  logic [2:0]            ltype_q, ltype_d;
  logic [LSB_W-1:0]      lsb_q, lsb_d;
  logic [N_SRC*XLEN-1:0] result_q, result_d;
  logic [4:0]            rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Extend the low 'bits' of v to XLEN, signed or unsigned, via shift pair.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v,
                                          input int bits,
                                          input logic sgn);
    logic [XLEN-1:0]        u;
    logic signed [XLEN-1:0] t;
    u = v << (XLEN - bits);
    t = signed'(u);
    if (sgn) ext = unsigned'(t >>> (XLEN - bits));
    else     ext = u >> (XLEN - bits);
  endfunction

  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0]  w,
                                               input logic [2:0]       t,
                                               input logic [LSB_W-1:0] lsb);
    logic [XLEN-1:0] sh_b, sh_h, sh_w;
    sh_b = w >> {lsb, 3'b000};
    sh_h = w >> {(lsb & ~LSB_W'(1)), 3'b000};
    sh_w = w >> {(lsb & ~LSB_W'(3)), 3'b000};
    case (t)
      3'b000:  fmt_load = ext(sh_b, 8, 1'b1);
      3'b100:  fmt_load = ext(sh_b, 8, 1'b0);
      3'b001:  fmt_load = ext(sh_h, 16, 1'b1);
      3'b101:  fmt_load = ext(sh_h, 16, 1'b0);
      3'b010:  fmt_load = ext(sh_w, 32, 1'b1);
      3'b110:  fmt_load = (XLEN == 64) ? ext(sh_w, 32, 1'b0) : w;
      default: fmt_load = w;
    endcase
  endfunction

  always_comb begin
    valid_d  = valid_q;
    wr_en_d  = wr_en_q;
    src_d    = src_q;
    ltype_d  = ltype_q;
    lsb_d    = lsb_q;
    result_d = result_q;
    rd_d     = rd_q;
    if (i_flushW) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
    end else if (!i_stallW) begin
      valid_d  = i_validM;
      wr_en_d  = i_ctrl_reg_wr_enM;
      src_d    = i_ctrl_result_srcM;
      ltype_d  = i_ctrl_load_typeM;
      lsb_d    = i_mem_addr_lsbM;
      result_d = i_result_concatM;
      rd_d     = i_regfile_rd_addrM;
    end
    // The entry sitting in W retires whenever it is not being held.
    cnt_d = (valid_q && !i_stallW) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      src_q    <= '0;
      ltype_q  <= '0;
      lsb_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_en_q  <= wr_en_d;
      src_q    <= src_d;
      ltype_q  <= ltype_d;
      lsb_q    <= lsb_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    o_regfile_rd_dataW = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (int'(src_q) == k) begin
        if (k == 1) o_regfile_rd_dataW = fmt_load(result_q[k*XLEN +: XLEN], ltype_q, lsb_q);
        else        o_regfile_rd_dataW = result_q[k*XLEN +: XLEN];
      end
    end
  end

  assign o_validW           = valid_q;
  assign o_ctrl_reg_wr_enW  = valid_q & wr_en_q & (rd_q != 5'd0);
  assign o_regfile_rd_addrW = rd_q;
  assign o_retire_cnt       = cnt_q;

endmodule

// File: tb/tb_riscv_writeback_stage.sv
// Directed scoreboard bench for riscv_writeback_stage at XLEN=32.
module tb_riscv_writeback_stage;

  localparam int XLEN  = 32;
  localparam int N_SRC = 4;
  localparam int CNT_W = 64;
  localparam int SEL_W = 2;
  localparam int LSB_W = 2;

  logic                  clk = 1'b0;
  logic                  rst, validM, stallW, flushW, wr_enM;
  logic [SEL_W-1:0]      srcM;
  logic [2:0]            ltypeM;
  logic [LSB_W-1:0]      lsbM;
  logic [XLEN-1:0]       alu, mem, pc4, csr;
  logic [4:0]            rdM;
  logic                  validW, wr_enW;
  logic [4:0]            addrW;
  logic [XLEN-1:0]       dataW;
  logic [CNT_W-1:0]      cnt;

  typedef struct {
    logic             v;
    logic             we;
    logic [4:0]       addr;
    logic [XLEN-1:0]  data;
    logic [CNT_W-1:0] cnt;
    bit               chk_dat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 0;

  riscv_writeback_stage #(.XLEN(XLEN), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_validM           (validM),
    .i_stallW           (stallW),
    .i_flushW           (flushW),
    .i_ctrl_reg_wr_enM  (wr_enM),
    .i_ctrl_result_srcM (srcM),
    .i_ctrl_load_typeM  (ltypeM),
    .i_mem_addr_lsbM    (lsbM),
    .i_result_concatM   ({csr, pc4, mem, alu}),
    .i_regfile_rd_addrM (rdM),
    .o_validW           (validW),
    .o_ctrl_reg_wr_enW  (wr_enW),
    .o_regfile_rd_addrW (addrW),
    .o_regfile_rd_dataW (dataW),
    .o_retire_cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input logic v, input logic we, input logic [4:0] addr,
                      input logic [XLEN-1:0] data, input logic [CNT_W-1:0] c,
                      input bit chk_dat);
    exp_t e;
    e.v = v; e.we = we; e.addr = addr; e.data = data; e.cnt = c; e.chk_dat = chk_dat;
    q.push_back(e);
  endtask

  task automatic ctl(input logic r, input logic v, input logic st, input logic fl);
    @(negedge clk);
    rst = r; validM = v; stallW = st; flushW = fl;
  endtask

  task automatic m(input logic we, input logic [SEL_W-1:0] s, input logic [2:0] lt,
                   input logic [LSB_W-1:0] l, input logic [4:0] rd);
    wr_enM = we; srcM = s; ltypeM = lt; lsbM = l; rdM = rd;
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a new W state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        cmp("validW", 64'(validW), 64'(e.v));
        cmp("wr_enW", 64'(wr_enW), 64'(e.we));
        cmp("retire_cnt", cnt, e.cnt);
        if (e.chk_dat) begin
          cmp("rd_addrW", 64'(addrW), 64'(e.addr));
          cmp("rd_dataW", 64'(dataW), 64'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; validM = 1'b1; stallW = 1'b0; flushW = 1'b0;
    alu = 32'hDEAD_BEEF; mem = 32'hBAAD_F00D; pc4 = 32'h1357_9BDF; csr = 32'hFFFF_FFFF;
    m(1'b1, 2'd1, 3'b001, 2'd3, 5'd31);

    ctl(1, 1, 0, 0); push(0, 0, 5'd0, 32'h0, 0, 1);
    ctl(1, 1, 1, 1); push(0, 0, 5'd0, 32'h0, 0, 1);

    ctl(0, 1, 0, 0); alu = 32'h1234_5678; m(1, 2'd0, 3'b000, 2'd0, 5'd5);
    push(1, 1, 5'd5, 32'h1234_5678, 0, 1);
    ctl(0, 1, 0, 0); pc4 = 32'h0000_0104; m(1, 2'd2, 3'b000, 2'd0, 5'd6);
    push(1, 1, 5'd6, 32'h0000_0104, 1, 1);

    mem = 32'h80FF_7F01;
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b000, 2'd3, 5'd7); push(1, 1, 5'd7, 32'hFFFF_FF80, 2, 1);
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b100, 2'd1, 5'd7); push(1, 1, 5'd7, 32'h0000_007F, 3, 1);
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b001, 2'd2, 5'd8); push(1, 1, 5'd8, 32'hFFFF_80FF, 4, 1);
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b101, 2'd0, 5'd8); push(1, 1, 5'd8, 32'h0000_7F01, 5, 1);
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b010, 2'd1, 5'd9); push(1, 1, 5'd9, 32'h80FF_7F01, 6, 1);
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b111, 2'd2, 5'd9); push(1, 1, 5'd9, 32'h80FF_7F01, 7, 1);
    ctl(0, 1, 0, 0); m(1, 2'd1, 3'b001, 2'd3, 5'd9); push(1, 1, 5'd9, 32'hFFFF_80FF, 8, 1);

    ctl(0, 1, 0, 0); alu = 32'h0000_0055; m(1, 2'd0, 3'b000, 2'd0, 5'd0);
    push(1, 0, 5'd0, 32'h0000_0055, 9, 1);

    ctl(0, 1, 0, 0); alu = 32'h0000_A5A5; m(1, 2'd0, 3'b000, 2'd0, 5'd10);
    push(1, 1, 5'd10, 32'h0000_A5A5, 10, 1);
    for (int i = 0; i < 3; i++) begin
      ctl(0, 1, 1, 0); push(1, 1, 5'd10, 32'h0000_A5A5, 10, 1);
    end

    ctl(0, 1, 0, 0); csr = 32'h0000_CAFE; m(1, 2'd3, 3'b000, 2'd0, 5'd11);
    push(1, 1, 5'd11, 32'h0000_CAFE, 11, 1);

    ctl(0, 1, 1, 1); alu = 32'h0BAD_0BAD; m(1, 2'd0, 3'b000, 2'd0, 5'd20);
    push(0, 0, 5'd0, 32'h0, 11, 0);

    ctl(0, 1, 0, 0); alu = 32'h0000_0077; m(1, 2'd0, 3'b000, 2'd0, 5'd12);
    push(1, 1, 5'd12, 32'h0000_0077, 11, 1);
    ctl(0, 1, 0, 1); alu = 32'h0000_0088; m(1, 2'd0, 3'b000, 2'd0, 5'd13);
    push(0, 0, 5'd0, 32'h0, 12, 0);

    ctl(0, 1, 0, 0); alu = 32'h0000_0099; m(1, 2'd0, 3'b000, 2'd0, 5'd14);
    push(1, 1, 5'd14, 32'h0000_0099, 12, 1);
    ctl(1, 1, 1, 1); push(0, 0, 5'd0, 32'h0, 0, 1);

    ctl(0, 1, 0, 0); pc4 = 32'h0000_0200; m(1, 2'd2, 3'b000, 2'd0, 5'd15);
    push(1, 1, 5'd15, 32'h0000_0200, 0, 1);
    ctl(0, 0, 0, 0); push(0, 0, 5'd0, 32'h0, 1, 0);
    stim_done = 1;
  end

  initial begin
    int budget;
    wait (stim_done);
    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
